// File: rtl/fb_ram_arbiter.sv
// fb_ram_arbiter: single-port frame-buffer RAM arbiter between a video
// scan-out reader (priority) and a CPU read/write port.
//
// Optional feature: define FB_ARB_STARVE_GUARD_EN to enable the CPU
// starvation guard (STARVE_LIMIT consecutive denials force one CPU grant).
// Default build: pure video priority, vid_miss held at 0.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   vid_req/vid_addr      scan-out read request and address
//   vid_rdata/vid_valid   registered read data and its one-cycle strobe
//   vid_miss              one-cycle pulse when a video request is denied
//   cpu_req/we/addr/wdata CPU request, held until cpu_ack
//   cpu_ack/cpu_rdata     completion pulse and registered read data
//   ram_addr/ram_we/ram_oe/ram_wdata/ram_rdata  RAM side (async read)
module fb_ram_arbiter #(
  parameter int unsigned A            = 12,
  parameter int unsigned D            = 8,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         vid_req,
  input  logic [A-1:0] vid_addr,
  output logic [D-1:0] vid_rdata,
  output logic         vid_valid,
  output logic         vid_miss,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [A-1:0] cpu_addr,
  input  logic [D-1:0] cpu_wdata,
  output logic         cpu_ack,
  output logic [D-1:0] cpu_rdata,
  output logic [A-1:0] ram_addr,
  output logic         ram_we,
  output logic [D-1:0] ram_wdata,
  output logic         ram_oe,
  input  logic [D-1:0] ram_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_VID, ST_CPU} state_e;

  // Elaboration-time range check of the starvation limit (4-bit counter).
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("fb_ram_arbiter: STARVE_LIMIT must be in 1..15");
  end

  state_e         state_q,     state_d;
  logic           busy_q,      busy_d;
  logic [A-1:0]   ram_addr_q,  ram_addr_d;
  logic           ram_we_q,    ram_we_d;
  logic [D-1:0]   ram_wdata_q, ram_wdata_d;
  logic [D-1:0]   vid_rdata_q, vid_rdata_d;
  logic           vid_valid_q, vid_valid_d;
  logic           vid_miss_q,  vid_miss_d;
  logic           cpu_ack_q,   cpu_ack_d;
  logic [D-1:0]   cpu_rdata_q, cpu_rdata_d;

  logic           cpu_pend;
  logic           grant_vid;
  logic           grant_cpu;

`ifdef FB_ARB_STARVE_GUARD_EN
  logic [3:0]     starve_q, starve_d;
`endif

  // A request seen in the ack cycle is the same transaction still held high.
  assign cpu_pend = cpu_req && !busy_q && !cpu_ack_q;

  // Grant decision.
`ifdef FB_ARB_STARVE_GUARD_EN
  assign grant_cpu = cpu_pend && (!vid_req || (starve_q >= 4'(STARVE_LIMIT)));
`else
  assign grant_cpu = cpu_pend && !vid_req;
`endif
  assign grant_vid = vid_req && !grant_cpu;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = ST_IDLE;
    busy_d      = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = '0;
    vid_rdata_d = vid_rdata_q;
    vid_valid_d = 1'b0;
    vid_miss_d  = 1'b0;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
`ifdef FB_ARB_STARVE_GUARD_EN
    starve_d    = starve_q;
`endif

    if (grant_vid) begin
      state_d    = ST_VID;
      ram_addr_d = vid_addr;
    end else if (grant_cpu) begin
      state_d     = ST_CPU;
      busy_d      = 1'b1;
      ram_addr_d  = cpu_addr;
      ram_we_d    = cpu_we;
      ram_wdata_d = cpu_we ? cpu_wdata : '0;
    end

`ifdef FB_ARB_STARVE_GUARD_EN
    vid_miss_d = vid_req && grant_cpu;
    if (grant_cpu) begin
      starve_d = '0;
    end else if (cpu_pend && (starve_q != 4'hF)) begin
      starve_d = starve_q + 4'd1;
    end
`endif

    // Completion of the access that occupied the current cycle.
    case (state_q)
      ST_VID: begin
        vid_valid_d = 1'b1;
        vid_rdata_d = ram_rdata;
      end
      ST_CPU: begin
        cpu_ack_d = 1'b1;
        if (!ram_we_q) begin
          cpu_rdata_d = ram_rdata;
        end
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      vid_rdata_q <= '0;
      vid_valid_q <= 1'b0;
      vid_miss_q  <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
`ifdef FB_ARB_STARVE_GUARD_EN
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      vid_rdata_q <= vid_rdata_d;
      vid_valid_q <= vid_valid_d;
      vid_miss_q  <= vid_miss_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
`ifdef FB_ARB_STARVE_GUARD_EN
      starve_q    <= starve_d;
`endif
    end
  end

  // Write strobe is masked by reset so an in-flight write cannot land on
  // the same edge that discards it.
  assign ram_we    = ram_we_q && !reset;
  assign ram_oe    = ram_we;
  assign ram_wdata = ram_oe ? ram_wdata_q : '0;

  assign ram_addr  = ram_addr_q;
  assign vid_rdata = vid_rdata_q;
  assign vid_valid = vid_valid_q;
  assign vid_miss  = vid_miss_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;

endmodule
